// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed scan driver feeding a seven-segment decoder.
// Latency: outputs are registered one cycle after the slot/commit decision.
// Backpressure: none; load is always accepted, the last load before a frame boundary wins.
module seg_scan_driver #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic [3:0]  an,
    output logic        frame
);

    localparam logic [19:0] CNT_MAX = 20'(PRESCALE - 1);

    logic [19:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_pend;
    logic        r_pv;
    logic [15:0] r_disp;

    logic        w_tick;
    logic        w_boundary;
    logic [1:0]  w_idx_nxt;
    logic [15:0] w_pend_nxt;
    logic        w_pv_nxt;
    logic [15:0] w_disp_nxt;
    logic [1:0]  w_msd;
    logic [3:0]  w_nib;
    logic [3:0]  w_an;

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_boundary = w_tick && (r_idx == 2'd3);
    assign w_idx_nxt  = w_tick ? r_idx + 2'd1 : r_idx;

    // Pending/display commit: loads park in pend, frame boundary moves them to disp.
    // A load landing on the boundary itself bypasses pend so the freshest value wins.
    always_comb begin
        w_pend_nxt = r_pend;
        w_pv_nxt   = r_pv;
        w_disp_nxt = r_disp;
        if (load) begin
            w_pend_nxt = value;
            w_pv_nxt   = 1'b1;
        end
        if (w_boundary) begin
            if (load) begin
                w_disp_nxt = value;
                w_pv_nxt   = 1'b0;
            end else if (r_pv) begin
                w_disp_nxt = r_pend;
                w_pv_nxt   = 1'b0;
            end
        end
    end

    // Most significant nonzero digit of the value about to be shown (0 when all zero).
    always_comb begin
        w_msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w_disp_nxt[4*i +: 4] != 4'h0) begin
                w_msd = 2'(i);
            end
        end
    end

    // Output decode from next-state slot and display value, so nibble and anode move together.
    always_comb begin
        w_nib = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
        if (blank_lz && (w_idx_nxt > w_msd)) begin
            w_an = 4'b1111;
        end else begin
            w_an = ~(4'b0001 << w_idx_nxt);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 20'd0;
            r_idx  <= 2'd0;
            r_pend <= 16'h0000;
            r_pv   <= 1'b0;
            r_disp <= 16'h0000;
            x0     <= 1'b0;
            x1     <= 1'b0;
            x2     <= 1'b0;
            x3     <= 1'b0;
            an     <= 4'b1111;
            frame  <= 1'b0;
        end else begin
            r_cnt  <= w_tick ? 20'd0 : r_cnt + 20'd1;
            r_idx  <= w_idx_nxt;
            r_pend <= w_pend_nxt;
            r_pv   <= w_pv_nxt;
            r_disp <= w_disp_nxt;
            x0     <= w_nib[3];
            x1     <= w_nib[2];
            x2     <= w_nib[1];
            x3     <= w_nib[0];
            an     <= w_an;
            frame  <= w_boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with PRESCALE=4: behavioural model plus literal spot checks.
// Model tracks edges since reset release; slot and frame derive from that count arithmetically.
// Inputs driven on the falling edge, outputs compared on the falling edge.
module tb_seg_scan_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        x0, x1, x2, x3;
    logic [3:0]  an;
    logic        frame;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_driver #(.PRESCALE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // Model state: k = rising edges since reset release.
    int          k = 0;
    bit          started = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pv = 0;
    logic [3:0]  e_nib = 4'h0;
    logic [3:0]  e_an = 4'hF;
    logic        e_frame = 1'b0;

    // Model update: what the display must show after each rising edge.
    always @(posedge clk) begin
        int idx;
        int msd;
        bit boundary;
        started = 1;
        if (reset) begin
            k = 0; m_disp = 0; m_pend = 0; m_pv = 0;
            e_nib = 0; e_an = 4'hF; e_frame = 0;
        end else begin
            k = k + 1;
            boundary = (k % (4*P)) == 0;
            if (boundary) begin
                if (load) m_disp = value;
                else if (m_pv) m_disp = m_pend;
                m_pv = 0;
            end else if (load) begin
                m_pend = value;
                m_pv = 1;
            end
            idx = (k / P) % 4;
            msd = 0;
            for (int i = 0; i < 4; i++)
                if (((m_disp >> (4*i)) & 16'hF) != 0) msd = i;
            e_nib = 4'((m_disp >> (4*idx)) & 16'hF);
            e_an = (blank_lz && idx > msd) ? 4'hF : ~(4'b0001 << idx);
            e_frame = boundary;
        end
    end

    function automatic logic [3:0] dut_nib();
        return {x0, x1, x2, x3};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (an !== e_an || dut_nib() !== e_nib || frame !== e_frame) begin
                miscompares++;
                $display("FAIL model k=%0d: got an=%b nib=%h frame=%b expected an=%b nib=%h frame=%b",
                         k, an, dut_nib(), frame, e_an, e_nib, e_frame);
            end
        end
    end

    // Wait until the model reports edge count t; bounded.
    task automatic wait_k(input int t);
        int n = 0;
        while (k != t && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (k != t) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout waiting for k=%0d (k=%0d)", t, k);
        end
    endtask

    // Present a one-cycle load sampled at edge t.
    task automatic load_at(input int t, input logic [15:0] v);
        wait_k(t - 1);
        value = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_an", {12'h0, an}, 16'hF);
        chk("reset_frame", {15'h0, frame}, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_an", {12'h0, an}, 16'hE);
        chk("first_nib", {12'h0, dut_nib()}, 16'h0);
        wait_k(4);  chk("scan_an1", {12'h0, an}, 16'hD);
        wait_k(12); chk("scan_an3", {12'h0, an}, 16'h7);
        wait_k(16); chk("scan_frame", {15'h0, frame}, 16'h1);
        chk("scan_wrap_an", {12'h0, an}, 16'hE);

        // Commit at boundary
        load_at(20, 16'h12AB);
        wait_k(31); chk("old_nib", {12'h0, dut_nib()}, 16'h0);
        wait_k(32); chk("commit_nib0", {12'h0, dut_nib()}, 16'hB);
        wait_k(36); chk("commit_nib1", {12'h0, dut_nib()}, 16'hA);
        wait_k(40); chk("commit_nib2", {12'h0, dut_nib()}, 16'h2);
        wait_k(44); chk("commit_nib3", {12'h0, dut_nib()}, 16'h1);
        chk("commit_an3", {12'h0, an}, 16'h7);

        // Last load wins
        load_at(50, 16'h1111);
        load_at(55, 16'h2222);
        wait_k(64); chk("last_wins", {12'h0, dut_nib()}, 16'h2);

        // Load coincident with boundary
        load_at(80, 16'h3333);
        chk("coincident_nib", {12'h0, dut_nib()}, 16'h3);
        chk("coincident_an", {12'h0, an}, 16'hE);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load_at(90, 16'h00A5);
        wait_k(96);  chk("lz_an0", {12'h0, an}, 16'hE);
        wait_k(100); chk("lz_an1", {12'h0, an}, 16'hD);
        wait_k(104); chk("lz_an2", {12'h0, an}, 16'hF);
        wait_k(108); chk("lz_an3", {12'h0, an}, 16'hF);
        load_at(110, 16'h0000);
        wait_k(112); chk("zero_an0", {12'h0, an}, 16'hE);
        wait_k(116); chk("zero_an1", {12'h0, an}, 16'hF);
        wait_k(117); blank_lz = 1'b0;
        wait_k(120); chk("relight_an2", {12'h0, an}, 16'hB);

        // Nibble weighting
        load_at(125, 16'h8421);
        wait_k(128); chk("weight0", {12'h0, x0, x1, x2, x3}, 16'h1);
        wait_k(132); chk("weight1", {12'h0, x0, x1, x2, x3}, 16'h2);
        wait_k(136); chk("weight2", {12'h0, x0, x1, x2, x3}, 16'h4);
        wait_k(140); chk("weight3", {12'h0, x0, x1, x2, x3}, 16'h8);

        // Mid-operation reset with a pending load
        load_at(150, 16'hBEEF);
        wait_k(153);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", {12'h0, an}, 16'hF);
        chk("midrst_nib", {12'h0, dut_nib()}, 16'h0);
        chk("midrst_frame", {15'h0, frame}, 16'h0);
        reset = 1'b0;
        wait_k(16); chk("midrst_f1", {12'h0, dut_nib()}, 16'h0);
        wait_k(32); chk("midrst_f2", {12'h0, dut_nib()}, 16'h0);
        wait_k(36); chk("midrst_f2s1", {12'h0, dut_nib()}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver that sits directly upstream of the seven-segment decoder. Holds a 16-bit (4 hex digit) display value and rotates through the four digits at a programmable rate. Each slot presents one nibble to the decoder inputs and drives the active-low digit-enable (anode) lines. New values are committed only at frame boundaries, so a frame is never torn, and leading zeros can optionally be blanked.

## Interface
- PRESCALE, 50000: clk cycles per digit slot; legal range 2..2^20; the counter is 20 bits wide.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  16  display value; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- load  input  1  single-cycle strobe; captures value into the pending register.
- blank_lz  input  1  1 = leading-zero digits are dark.
- x0, x1, x2, x3  output  1 each  nibble to the decoder, with fixed weights x0=8, x1=4, x2=2, x3=1; registered.
- an  output  4  digit enables, active-low, one-hot-low; an[i]=0 lights digit i; registered.
- frame  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0; registered.

## Operation
- Prescaler `cnt` counts 0..PRESCALE-1 and then wraps to 0. `tick` is asserted when cnt==PRESCALE-1.
- Slot index `idx` (2 bits) increments on tick: 0→1→2→3→0. The 3→0 transition is the frame boundary.
- Registers:
  - `pend` (16 bits) with flag `pv`.
  - `disp` (16 bits) holds the value currently shown.
- load=1: pend←value, pv←1. A second load before the boundary overwrites pend; the last load wins.
- At a frame boundary with pv=1: disp←pend, pv←0.
- If load and the frame boundary occur in the same cycle, disp←value directly and pv←0. The freshest value wins.
- Output stage, computed from the next-state idx and disp:
  - {x0,x1,x2,x3} = disp nibble of idx.
  - an = ~(4'b0001 << idx).
- Leading-zero blanking, when blank_lz=1:
  - Let msd = index of the highest nonzero nibble of disp, or 0 if disp==0.
  - Slots with idx > msd drive an=4'b1111, and the nibble is still presented.
  - Digit 0 is never blanked, so disp==0 shows a single "0".
- blank_lz is sampled every cycle; no commit is needed.
- No other state; no handshake back-pressure. load is always accepted.

## Timing
- Reset values, asserted while reset=1: cnt=0, idx=0, disp=0, pend=0, pv=0, x0..x3=0, an=4'b1111, frame=0.
- First cycle after reset release: an=4'b1110, nibble=0 (idx 0, disp 0).
- Slot length is exactly PRESCALE cycles. A full frame is 4×PRESCALE cycles.
- Output latency is one cycle. an, the nibble and frame change on the edge following the cycle where tick=1.
- frame is high for exactly one cycle, in the same cycle an first shows 4'b1110 of the new frame.
- Load-to-display latency ranges from 1 cycle (load coincident with the boundary) to 4×PRESCALE cycles.
- Reset asserted mid-frame: everything returns to reset values on the next edge, and pending data is discarded.
- Only one an bit is ever low. No glitch or overlap: the nibble and an update on the same edge.

## Test plan
- **Reset / scan:** PRESCALE=4, reset 2 cycles, then no load.
  - an is 1111 during reset.
  - an is 1110 from the first cycle after release, then 1101, 1011, 0111 every 4 cycles.
  - frame pulses every 16 cycles.
  - Nibble is 0 throughout.
- **Commit at boundary:** PRESCALE=4, load value=16'h12AB mid-frame.
  - Old digits (0) continue until the frame pulse.
  - Next frame shows x-nibbles B, A, 2, 1 on an=1110, 1101, 1011, 0111.
- **Last load wins / coincident load:**
  - Loads of 16'h1111 then 16'h2222 within one frame → the frame after the boundary shows 2222.
  - Load 16'h3333 in the exact cycle tick=1 with idx=3 → an=1110 shows 3 on the next edge.
- **Leading-zero blank:** blank_lz=1.
  - disp=16'h00A5 → an goes 1110, 1101, 1111, 1111.
  - disp=0 → only an=1110 is lit, with nibble 0.
  - Toggling blank_lz to 0 relights all slots in the next slot.
- **Nibble weighting:** disp=16'h8421.
  - Slot 0: {x0,x1,x2,x3}=0001.
  - Slot 1: 0010.
  - Slot 2: 0100.
  - Slot 3: 1000.
- **Mid-operation reset:** pending load outstanding, reset at idx=2 → all outputs return to reset values on the next edge. After release, disp=0 is shown and the pending value never appears.
